pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives pc_write_o, the IF/ID hold (hazard) and flush inputs, and the ID/EX bubble.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-cache freezes.
- Keeps stall/flush statistics and a memory-wait watchdog.

---
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             mem_stall_i;
    logic             pc_write_o;
    logic             ifid_hazard_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    // The controller side
    modport slave (
        input  ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_stall_i,
        output pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o,
               pipe_freeze_o, stall_cnt_o, flush_cnt_o, err_o
    );

    // The pipeline side
    modport master (
        output ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_stall_i,
        input  pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o,
               pipe_freeze_o, stall_cnt_o, flush_cnt_o, err_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with statistics and watchdog
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [15:0]      WAIT_MAX = 16'hFFFF;
    localparam logic [15:0]      WAIT_TO  = 16'(TIMEOUT);

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             err_q, err_d;

    logic load_use, br;
    logic pc_write, hazard, flush, bubble, freeze;

    // Decide this cycle's control outputs and the next register values
    always_comb begin
        load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));
        br       = bus.branch_taken_i | pending_q;

        pc_write  = 1'b1;
        hazard    = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        freeze    = 1'b0;
        state_d   = state_q;
        pending_d = pending_q;
        wait_d    = wait_q;
        flush_d   = flush_q;
        err_d     = err_q;

        if (rst_i) begin
            // Keep the front end parked on a NOP while reset is held
            pc_write = 1'b0;
            flush    = 1'b1;
        end else if (bus.mem_stall_i) begin
            pc_write = 1'b0;
            hazard   = 1'b1;
            freeze   = 1'b1;
            if (state_q == RUN) begin
                // A branch seen together with the stall is remembered, not dropped
                pending_d = br;
                state_d   = MEM_WAIT;
                wait_d    = 16'd1;
            end else begin
                pending_d = pending_q | bus.branch_taken_i;
                if (wait_q != WAIT_MAX) wait_d = wait_q + 16'd1;
                if (wait_q == WAIT_TO)  err_d  = 1'b1;
            end
        end else begin
            // Release cycle of MEM_WAIT behaves exactly like RUN
            if (state_q == MEM_WAIT) begin
                state_d = RUN;
                wait_d  = 16'd0;
            end
            if (load_use) begin
                // Branch is re-resolved by ID once the load-use bubble clears
                pc_write = 1'b0;
                hazard   = 1'b1;
                bubble   = 1'b1;
            end else if (br) begin
                flush     = 1'b1;
                pending_d = 1'b0;
                if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
            end
        end

        stall_d = stall_q;
        if (!rst_i && !pc_write && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    end

    // State, flags and statistics registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
            wait_q    <= 16'd0;
            stall_q   <= '0;
            flush_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            err_q     <= err_d;
        end
    end

    assign bus.pc_write_o    = pc_write;
    assign bus.ifid_hazard_o = hazard;
    assign bus.ifid_flush_o  = flush;
    assign bus.idex_bubble_o = bubble;
    assign bus.pipe_freeze_o = freeze;
    assign bus.stall_cnt_o   = stall_q;
    assign bus.flush_cnt_o   = flush_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_pass_m = 0, n_tot_m = 0;
    int n_pass_d = 0, n_tot_d = 0;

    task automatic chk_m(input string name, input longint act, input longint exp);
        n_tot_m++;
        if (act == exp) n_pass_m++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_d(input string name, input longint act, input longint exp);
        n_tot_d++;
        if (act == exp) n_pass_d++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: "waiting" is how many cycles into a cache stall we are
    bit m_waiting;
    int m_wait_len;
    bit m_owed_flush;
    int m_stalls, m_flushes;
    bit m_err;

    always @(negedge clk_i or posedge rst_i) begin
        bit lu, br;
        int e_pc, e_hz, e_fl, e_bb, e_fz;
        if (rst_i) begin
            m_waiting = 0; m_wait_len = 0; m_owed_flush = 0;
            m_stalls = 0; m_flushes = 0; m_err = 0;
            if (!clk_i) begin
                chk_m("rst_pc_write", bus.pc_write_o, 0);
                chk_m("rst_flush", bus.ifid_flush_o, 1);
                chk_m("rst_hazard", bus.ifid_hazard_o, 0);
                chk_m("rst_bubble", bus.idex_bubble_o, 0);
                chk_m("rst_freeze", bus.pipe_freeze_o, 0);
                chk_m("rst_stall_cnt", bus.stall_cnt_o, 0);
                chk_m("rst_flush_cnt", bus.flush_cnt_o, 0);
                chk_m("rst_err", bus.err_o, 0);
            end
        end else begin
            lu = bus.idex_memread_i && bus.idex_rt_i != 0 &&
                 (bus.idex_rt_i == bus.ifid_rs_i || bus.idex_rt_i == bus.ifid_rt_i);
            br = bus.branch_taken_i || m_owed_flush;
            chk_m("stall_cnt", bus.stall_cnt_o, m_stalls);
            chk_m("flush_cnt", bus.flush_cnt_o, m_flushes);
            chk_m("err", bus.err_o, m_err);
            if (bus.mem_stall_i) begin
                {e_pc, e_hz, e_fl, e_bb, e_fz} = {32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
                if (!m_waiting) begin
                    m_owed_flush = br;
                    m_waiting = 1;
                    m_wait_len = 1;
                end else begin
                    m_owed_flush = m_owed_flush || bus.branch_taken_i;
                    if (m_wait_len == TIMEOUT) m_err = 1;
                    if (m_wait_len < 65535) m_wait_len++;
                end
            end else begin
                m_waiting = 0;
                m_wait_len = 0;
                if (lu) begin
                    {e_pc, e_hz, e_fl, e_bb, e_fz} = {32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
                end else if (br) begin
                    {e_pc, e_hz, e_fl, e_bb, e_fz} = {32'd1, 32'd0, 32'd1, 32'd0, 32'd0};
                    m_owed_flush = 0;
                    if (m_flushes < CMAX) m_flushes++;
                end else begin
                    {e_pc, e_hz, e_fl, e_bb, e_fz} = {32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
                end
            end
            if (e_pc == 0 && m_stalls < CMAX) m_stalls++;
            chk_m("pc_write", bus.pc_write_o, e_pc);
            chk_m("ifid_hazard", bus.ifid_hazard_o, e_hz);
            chk_m("ifid_flush", bus.ifid_flush_o, e_fl);
            chk_m("idex_bubble", bus.idex_bubble_o, e_bb);
            chk_m("pipe_freeze", bus.pipe_freeze_o, e_fz);
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        bus.ifid_rs_i = 0; bus.ifid_rt_i = 0; bus.idex_memread_i = 0;
        bus.idex_rt_i = 0; bus.branch_taken_i = 0; bus.mem_stall_i = 0;
    endtask

    task automatic do_reset;
        idle();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int burst;
        idle();
        tick();
        // Reset behaviour and idle after release
        do_reset();
        #3;
        chk_d("idle_pc_write", bus.pc_write_o, 1);
        chk_d("idle_flush", bus.ifid_flush_o, 0);

        // Load-use on rs, then rt=0 gives no stall
        tick();
        bus.idex_memread_i = 1; bus.idex_rt_i = 8; bus.ifid_rs_i = 8;
        #3;
        chk_d("lu_pc_write", bus.pc_write_o, 0);
        chk_d("lu_hazard", bus.ifid_hazard_o, 1);
        chk_d("lu_bubble", bus.idex_bubble_o, 1);
        tick();
        bus.idex_rt_i = 0; bus.ifid_rs_i = 0;
        #3;
        chk_d("lu_stall_cnt", bus.stall_cnt_o, 1);
        chk_d("lu_r0_pc_write", bus.pc_write_o, 1);

        // Branch flush for exactly one cycle
        do_reset();
        bus.branch_taken_i = 1;
        #3;
        chk_d("br_flush", bus.ifid_flush_o, 1);
        chk_d("br_pc_write", bus.pc_write_o, 1);
        tick();
        bus.branch_taken_i = 0;
        #3;
        chk_d("br_flush_after", bus.ifid_flush_o, 0);
        chk_d("br_flush_cnt", bus.flush_cnt_o, 1);

        // Branch coincident with a 5-cycle cache stall
        do_reset();
        bus.branch_taken_i = 1; bus.mem_stall_i = 1;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk_d("def_freeze", bus.pipe_freeze_o, 1);
            chk_d("def_no_flush", bus.ifid_flush_o, 0);
            tick();
            bus.branch_taken_i = 0;
            if (i == 4) bus.mem_stall_i = 0;
        end
        #3;
        chk_d("def_release_flush", bus.ifid_flush_o, 1);
        chk_d("def_release_freeze", bus.pipe_freeze_o, 0);
        tick();
        #3;
        chk_d("def_flush_once", bus.ifid_flush_o, 0);
        chk_d("def_flush_cnt", bus.flush_cnt_o, 1);
        chk_d("def_stall_cnt", bus.stall_cnt_o, 5);

        // Watchdog with TIMEOUT=4 and a 6-cycle stall
        do_reset();
        bus.mem_stall_i = 1;
        for (int c = 1; c <= 8; c++) begin
            #3;
            chk_d("wd_err", bus.err_o, (c >= 6) ? 1 : 0);
            tick();
            if (c == 6) bus.mem_stall_i = 0;
        end

        // Asynchronous reset during a wait with a flush owed
        do_reset();
        bus.branch_taken_i = 1; bus.mem_stall_i = 1;
        tick();
        bus.branch_taken_i = 0;
        #1;
        rst_i = 1;
        #1;
        chk_d("arst_pc_write", bus.pc_write_o, 0);
        chk_d("arst_flush", bus.ifid_flush_o, 1);
        chk_d("arst_freeze", bus.pipe_freeze_o, 0);
        chk_d("arst_flush_cnt", bus.flush_cnt_o, 0);
        rst_i = 0;
        tick();
        bus.mem_stall_i = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk_d("arst_no_flush", bus.ifid_flush_o, 0);
            tick();
        end
        chk_d("arst_flush_cnt_after", bus.flush_cnt_o, 0);

        // Randomized traffic with stall bursts and occasional resets
        do_reset();
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            bus.ifid_rs_i      = 5'($urandom_range(0, 3));
            bus.ifid_rt_i      = 5'($urandom_range(0, 3));
            bus.idex_rt_i      = 5'($urandom_range(0, 3));
            bus.idex_memread_i = ($urandom_range(0, 99) < 40);
            bus.branch_taken_i = ($urandom_range(0, 99) < 20);
            if (burst == 0 && $urandom_range(0, 99) < 12) burst = $urandom_range(1, 8);
            bus.mem_stall_i = (burst > 0);
            if (burst > 0) burst--;
            rst_i = ($urandom_range(0, 999) < 5);
            if (rst_i) burst = 0;
            tick();
        end
        rst_i = 0;
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass_m + n_pass_d, n_tot_m + n_tot_d);
        $finish;
    end
endmodule
